thor2024_macro_expander: RTL and testbench

THOR2024_MACRO_EXPANDER -- requirements
Module: Thor2024_macro_expander

---
 rtl/thor2024_macro_expander.sv | 252 +++++++++++++++++++++++++
 tb/tb_thor2024_macro_expander.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2024_macro_expander.sv
// thor2024_macro_expander: cracks PUSH/POP/ENTER/LEAVE macro instructions into
// ADDI/MOV/LOAD/STORE micro-ops; every other instruction passes through.
// Optional feature macro: THOR2024_ENTER_LEAVE_EN expands ENTER/LEAVE; without
// it they are reported as illegal (single PASS with out_exc=1).
// Opcode field is instr[6:0]. PASS uops carry rd/ra/imm = 0; expanded uops
// carry the parent macro instruction on out_instr for tracing.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; out_valid and every out_* field hold steady until that transfer.

package thor2024_macro_pkg;
    typedef logic [39:0] instruction_t;
    localparam logic [6:0] OP_PUSH    = 7'h58;
    localparam logic [6:0] OP_POP     = 7'h59;
    localparam logic [6:0] OP_ENTER   = 7'h5A;
    localparam logic [6:0] OP_LEAVE   = 7'h5B;
    localparam logic [2:0] KIND_PASS  = 3'd0;
    localparam logic [2:0] KIND_ADDI  = 3'd1;
    localparam logic [2:0] KIND_MOV   = 3'd2;
    localparam logic [2:0] KIND_LOAD  = 3'd3;
    localparam logic [2:0] KIND_STORE = 3'd4;
endpackage

module thor2024_macro_expander
    import thor2024_macro_pkg::*;
#(
    parameter logic [5:0] REG_SP = 6'd31,
    parameter logic [5:0] REG_FP = 6'd30,
    parameter logic [5:0] REG_LR = 6'd29
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               in_valid,
    input  instruction_t       in_instr,
    input  logic               in_macro,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_kind,
    output instruction_t       out_instr,
    output logic [5:0]         out_rd,
    output logic [5:0]         out_ra,
    output logic signed [31:0] out_imm,
    output logic               out_last,
    output logic               out_exc,
    output logic               dbg_state_o
);

`ifdef THOR2024_ENTER_LEAVE_EN
    localparam bit ENTER_LEAVE_EN = 1'b1;
`else
    localparam bit ENTER_LEAVE_EN = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [2:0]   step_q, step_d;
    logic         valid_q, valid_d;
    logic [2:0]   kind_q, kind_d;
    instruction_t instr_q, instr_d;
    logic [5:0]   rd_q, rd_d, ra_q, ra_d;
    logic [31:0]  imm_q, imm_d;
    logic         last_q, last_d, exc_q, exc_d;

    // Uop generator: which uop the instruction produces at a given step
    instruction_t g_instr;
    logic [2:0]   g_step, g_n, g_kind;
    logic [5:0]   g_n8, g_rd, g_ra;
    logic [1:0]   g_k;
    logic [31:0]  g_imm, g_frame;
    logic         g_last, g_recog;

    function automatic logic [5:0] list_reg(input instruction_t ins, input logic [1:0] k);
        case (k)
            2'd0:    return ins[12:7];
            2'd1:    return ins[18:13];
            2'd2:    return ins[24:19];
            default: return ins[30:25];
        endcase
    endfunction

    assign in_ready    = (state_q == IDLE) && !flush && (!valid_q || out_ready);
    assign out_valid   = valid_q;
    assign out_kind    = kind_q;
    assign out_instr   = instr_q;
    assign out_rd      = rd_q;
    assign out_ra      = ra_q;
    assign out_imm     = imm_q;
    assign out_last    = last_q;
    assign out_exc     = exc_q;
    assign dbg_state_o = (state_q == EXPAND);

    // Decode the uop for (instruction, step): step 0 of the incoming instruction
    // while idle, the following step of the latched macro while expanding.
    always_comb begin
        g_instr = (state_q == IDLE) ? in_instr : instr_q;
        g_step  = (state_q == IDLE) ? 3'd0 : step_q + 3'd1;
        g_n     = {1'b0, g_instr[32:31]} + 3'd1;
        g_n8    = {g_n, 3'b000};
        g_frame = {8'd0, g_instr[39:16]};
        g_k     = 2'd0;
        g_kind  = KIND_PASS;
        g_rd    = '0;
        g_ra    = '0;
        g_imm   = '0;
        g_last  = 1'b1;
        g_recog = 1'b0;
        case (g_instr[6:0])
            OP_PUSH: begin
                g_recog = 1'b1;
                g_ra    = REG_SP;
                if (g_step == 3'd0) begin
                    g_kind = KIND_ADDI;
                    g_rd   = REG_SP;
                    g_imm  = 32'd0 - {26'd0, g_n8};
                    g_last = 1'b0;
                end else begin
                    g_k    = g_step[1:0] - 2'd1;
                    g_kind = KIND_STORE;
                    g_rd   = list_reg(g_instr, g_k);
                    g_imm  = {27'd0, g_k, 3'b000};
                    g_last = (g_step == g_n);
                end
            end
            OP_POP: begin
                g_recog = 1'b1;
                g_ra    = REG_SP;
                if (g_step < g_n) begin
                    g_k    = g_step[1:0];
                    g_kind = KIND_LOAD;
                    g_rd   = list_reg(g_instr, g_k);
                    g_imm  = {27'd0, g_k, 3'b000};
                    g_last = 1'b0;
                end else begin
                    g_kind = KIND_ADDI;
                    g_rd   = REG_SP;
                    g_imm  = {26'd0, g_n8};
                end
            end
            OP_ENTER: begin
                g_recog = ENTER_LEAVE_EN;
                g_ra    = REG_SP;
                g_last  = 1'b0;
                case (g_step)
                    3'd0: begin g_kind = KIND_STORE; g_rd = REG_FP; g_imm = 32'hFFFF_FFF8; end
                    3'd1: begin g_kind = KIND_STORE; g_rd = REG_LR; g_imm = 32'hFFFF_FFF0; end
                    3'd2: begin g_kind = KIND_ADDI;  g_rd = REG_SP; g_imm = 32'hFFFF_FFF0; end
                    3'd3: begin g_kind = KIND_MOV;   g_rd = REG_FP; g_last = (g_frame == 32'd0); end
                    default: begin g_kind = KIND_ADDI; g_rd = REG_SP; g_imm = 32'd0 - g_frame; g_last = 1'b1; end
                endcase
            end
            OP_LEAVE: begin
                g_recog = ENTER_LEAVE_EN;
                g_ra    = REG_SP;
                g_last  = 1'b0;
                case (g_step)
                    3'd0: begin g_kind = KIND_MOV;  g_rd = REG_SP; g_ra = REG_FP; end
                    3'd1: begin g_kind = KIND_LOAD; g_rd = REG_LR; end
                    3'd2: begin g_kind = KIND_LOAD; g_rd = REG_FP; g_imm = 32'd8; end
                    default: begin g_kind = KIND_ADDI; g_rd = REG_SP; g_imm = 32'd16 + g_frame; g_last = 1'b1; end
                endcase
            end
            default: g_recog = 1'b0;
        endcase
    end

    // Next state: accept/pass-through while idle, walk the steps while expanding
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        valid_d = valid_q;
        kind_d  = kind_q;
        instr_d = instr_q;
        rd_d    = rd_q;
        ra_d    = ra_q;
        imm_d   = imm_q;
        last_d  = last_q;
        exc_d   = exc_q;
        if (flush) begin
            state_d = IDLE;
            step_d  = '0;
            valid_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (in_valid && in_ready) begin
                valid_d = 1'b1;
                instr_d = in_instr;
                step_d  = '0;
                if (in_macro && g_recog) begin
                    state_d = EXPAND;
                    kind_d  = g_kind;
                    rd_d    = g_rd;
                    ra_d    = g_ra;
                    imm_d   = g_imm;
                    last_d  = g_last;
                    exc_d   = 1'b0;
                end else begin
                    kind_d  = KIND_PASS;
                    rd_d    = '0;
                    ra_d    = '0;
                    imm_d   = '0;
                    last_d  = 1'b1;
                    exc_d   = in_macro;
                end
            end else if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
        end else if (valid_q && out_ready) begin
            if (last_q) begin
                state_d = IDLE;
                step_d  = '0;
                valid_d = 1'b0;
            end else begin
                step_d  = step_q + 3'd1;
                kind_d  = g_kind;
                rd_d    = g_rd;
                ra_d    = g_ra;
                imm_d   = g_imm;
                last_d  = g_last;
                exc_d   = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            valid_q <= 1'b0;
            kind_q  <= '0;
            instr_q <= '0;
            rd_q    <= '0;
            ra_q    <= '0;
            imm_q   <= '0;
            last_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            ra_q    <= ra_d;
            imm_q   <= imm_d;
            last_q  <= last_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_thor2024_macro_expander.sv
// Bench for thor2024_macro_expander: directed scenarios plus randomized traffic,
// every delivered uop compared against a reference expansion list.
`timescale 1ns/1ps
module tb_thor2024_macro_expander;
  import thor2024_macro_pkg::*;

  localparam logic [5:0] SP = 6'd31;
  localparam logic [5:0] FP = 6'd30;
  localparam logic [5:0] LR = 6'd29;
`ifdef THOR2024_ENTER_LEAVE_EN
  localparam bit EL_EN = 1'b1;
`else
  localparam bit EL_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_macro, in_ready, flush;
  logic [39:0] in_instr;
  logic        out_valid, out_ready, out_last, out_exc, dbg_state_o;
  logic [2:0]  out_kind;
  logic [39:0] out_instr;
  logic [5:0]  out_rd, out_ra;
  logic signed [31:0] out_imm;

  thor2024_macro_expander dut (
    .rst(rst), .clk(clk), .in_valid(in_valid), .in_instr(in_instr), .in_macro(in_macro),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_instr(out_instr), .out_rd(out_rd), .out_ra(out_ra),
    .out_imm(out_imm), .out_last(out_last), .out_exc(out_exc), .dbg_state_o(dbg_state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard: {exc, last, imm, ra, rd, kind, instr}
  logic [88:0] exp_q[$];
  logic [88:0] exp_v;
  logic [88:0] held;
  logic        stall_prev = 1'b0;
  wire  [88:0] obs = {out_exc, out_last, out_imm, out_ra, out_rd, out_kind, out_instr};

  function automatic logic [88:0] mk(input logic [2:0] kind, input logic [5:0] rd, input logic [5:0] ra,
                                     input logic [31:0] imm, input logic last, input logic exc,
                                     input logic [39:0] ins);
    return {exc, last, imm, ra, rd, kind, ins};
  endfunction

  // reference expansion as a list of uops per instruction
  task automatic model(input logic [39:0] ins, input logic mac);
    int n, imm;
    logic [5:0] r[4];
    logic [6:0] op;
    logic recog;
    op = ins[6:0];
    n = int'(ins[32:31]) + 1;
    imm = int'({8'd0, ins[39:16]});
    r[0] = ins[12:7]; r[1] = ins[18:13]; r[2] = ins[24:19]; r[3] = ins[30:25];
    recog = (op == OP_PUSH) || (op == OP_POP) || (EL_EN && (op == OP_ENTER || op == OP_LEAVE));
    if (!mac || !recog) begin
      exp_q.push_back(mk(3'd0, 6'd0, 6'd0, 32'd0, 1'b1, mac, ins));
    end else if (op == OP_PUSH) begin
      exp_q.push_back(mk(3'd1, SP, SP, 32'(-8 * n), 1'b0, 1'b0, ins));
      for (int k = 0; k < n; k++) exp_q.push_back(mk(3'd4, r[k], SP, 32'(8 * k), k == n - 1, 1'b0, ins));
    end else if (op == OP_POP) begin
      for (int k = 0; k < n; k++) exp_q.push_back(mk(3'd3, r[k], SP, 32'(8 * k), 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd1, SP, SP, 32'(8 * n), 1'b1, 1'b0, ins));
    end else if (op == OP_ENTER) begin
      exp_q.push_back(mk(3'd4, FP, SP, 32'(-8), 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd4, LR, SP, 32'(-16), 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd1, SP, SP, 32'(-16), 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd2, FP, SP, 32'd0, imm == 0, 1'b0, ins));
      if (imm != 0) exp_q.push_back(mk(3'd1, SP, SP, 32'(-imm), 1'b1, 1'b0, ins));
    end else begin
      exp_q.push_back(mk(3'd2, SP, FP, 32'd0, 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd3, LR, SP, 32'd0, 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd3, FP, SP, 32'd8, 1'b0, 1'b0, ins));
      exp_q.push_back(mk(3'd1, SP, SP, 32'(16 + imm), 1'b1, 1'b0, ins));
    end
  endtask

  // monitor: compare each handshake, and check fields hold across stalls
  always @(negedge clk) begin
    if (rst || flush) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        assert (out_valid === 1'b1 && obs === held) else begin
          errors++;
          $error("FAIL hold valid=%b obs=%h exp=%h", out_valid, obs, held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_uop obs=%h exp=none", obs);
        end
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          assert (obs === exp_v) else begin
            errors++;
            $error("FAIL uop obs=%h exp=%h", obs, exp_v);
          end
        end
      end
      stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
      held = obs;
    end
  end

  // out_ready driver: 0 always ready, 1 random, 2 toggling
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  function automatic logic [39:0] mk_list(input logic [6:0] op, input int n, input logic [5:0] a,
                                          input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
    logic [39:0] t;
    t = rnd40();
    t[6:0] = op; t[12:7] = a; t[18:13] = b; t[24:19] = c; t[30:25] = d;
    t[32:31] = 2'(n - 1);
    return t;
  endfunction

  function automatic logic [39:0] mk_frame(input logic [6:0] op, input logic [23:0] imm);
    logic [39:0] t;
    t = rnd40();
    t[6:0] = op; t[39:16] = imm;
    return t;
  endfunction

  function automatic logic [5:0] rreg();
    return 6'($urandom_range(0, 63));
  endfunction

  // driver: present one instruction (called just after a rising edge)
  task automatic send(input logic [39:0] ins, input logic mac);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_instr = ins; in_macro = mac;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (waited < 200) else begin
      errors++;
      $error("FAIL accept_timeout waited=%0d limit=200", waited);
    end
    @(posedge clk);
    model(ins, mac);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain left=%0d exp=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    logic [39:0] t;
    rst = 1'b1; in_valid = 1'b0; in_macro = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (obs === 89'd0 && out_valid === 1'b0 && dbg_state_o === 1'b0) else begin
      errors++;
      $error("FAIL reset obs=%h valid=%b state=%b exp=0", obs, out_valid, dbg_state_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // PUSH n=3 r5,r6,r7, always ready: in_ready low for exactly 4 cycles
    rdy_mode = 0;
    send(mk_list(OP_PUSH, 3, 6'd5, 6'd6, 6'd7, 6'd9), 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      assert (in_ready === 1'b0) else begin
        errors++;
        $error("FAIL push_busy cycle=%0d in_ready=%b exp=0", i, in_ready);
      end
    end
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL push_done in_ready=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    drain();

    // ENTER imm=64 with toggling ready
    rdy_mode = 2;
    send(mk_frame(OP_ENTER, 24'd64), 1'b1);
    drain();

    // ENTER imm=0: MOV is the last uop
    rdy_mode = 0;
    send(mk_frame(OP_ENTER, 24'd0), 1'b1);
    drain();

    // POP n=2, flush right after the first LOAD handshake
    send(mk_list(OP_POP, 2, rreg(), rreg(), rreg(), rreg()), 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    assert (out_valid === 1'b0 && dbg_state_o === 1'b0) else begin
      errors++;
      $error("FAIL flush valid=%b state=%b exp=0/0", out_valid, dbg_state_o);
    end
    exp_q.delete();
    t = rnd40(); t[6:0] = 7'h04;
    send(t, 1'b0);
    drain();

    // back-to-back pass-through, no bubbles
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(rnd40(), 1'b0);
    checks++;
    assert (cyc - c0 == 4) else begin
      errors++;
      $error("FAIL b2b cycles=%0d exp=4", cyc - c0);
    end
    drain();

    // reset in the middle of LEAVE
    rdy_mode = 1;
    send(mk_frame(OP_LEAVE, 24'($urandom_range(0, 1000))), 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    assert (obs === 89'd0 && out_valid === 1'b0 && dbg_state_o === 1'b0) else begin
      errors++;
      $error("FAIL reset_mid obs=%h valid=%b state=%b exp=0", obs, out_valid, dbg_state_o);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      assert (out_valid === 1'b0) else begin
        errors++;
        $error("FAIL post_reset cycle=%0d valid=%b exp=0", i, out_valid);
      end
    end
    @(posedge clk); #1;

    // LEAVE: expanded when the feature is built in, illegal otherwise
    rdy_mode = 0;
    send(mk_frame(OP_LEAVE, 24'd5), 1'b1);
    drain();

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: send(rnd40(), 1'b0);
        1: send(mk_list(OP_PUSH, int'($urandom_range(1, 4)), rreg(), rreg(), rreg(), rreg()), 1'b1);
        2: send(mk_list(OP_POP, int'($urandom_range(1, 4)), rreg(), rreg(), rreg(), rreg()), 1'b1);
        3: send(mk_frame(OP_ENTER, ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom())), 1'b1);
        4: send(mk_frame(OP_LEAVE, 24'($urandom())), 1'b1);
        default: begin
          t = rnd40(); t[6:0] = 7'($urandom_range(0, 87));
          send(t, 1'b1);
        end
      endcase
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
